// File: rtl/bcd_calendar_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_calendar_sequencer
//
// Purpose:
//   Day-granular BCD calendar (YYYY-MM-DD). It advances one day for each
//   accepted advance request and accepts software loads that are checked
//   before they are committed. One leap-year evaluator is shared between two
//   jobs: checking the year of a pending load, and refreshing the leap flag
//   after every change of the current year.
//
// Parameters:
//   RESET_YEAR   BCD year after reset  {thousands, hundreds, tens, ones}
//   RESET_MONTH  BCD month after reset
//   RESET_DAY    BCD day after reset
//   RESET_DOW    day of week after reset (CAL_DOW_EN builds only)
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   synchronous, active-high reset
//   load         in   1   load request, sampled only while ready=1
//   load_year    in  16   BCD year to load
//   load_month   in   8   BCD month to load
//   load_day     in   8   BCD day to load
//   load_dow     in   3   day of week to load (CAL_DOW_EN builds only)
//   adv          in   1   advance one day; accepted when adv & ready & ~load
//   ready        out  1   block accepts load/adv in this cycle
//   year         out 16   current BCD year
//   month        out  8   current BCD month
//   day          out  8   current BCD day
//   leap         out  1   current year is a leap year
//   dow          out  3   day of week, 0=Sunday..6=Saturday (CAL_DOW_EN only)
//   year_wrap    out  1   one-cycle pulse when the year rolls 9999 -> 0000
//   load_err     out  1   one-cycle pulse when a load was rejected
//
// Configuration:
//   CAL_DOW_EN   when defined, adds the day-of-week counter together with
//                RESET_DOW, load_dow and dow. When undefined, none of these
//                exist and all other behaviour is unchanged.
// ---------------------------------------------------------------------------

// Leap-year test on a four-digit BCD year. A year is a leap year when its
// last two digits are divisible by 4 and not 00, or, for a century year
// (last two digits 00), when its first two digits are divisible by 4
// (that is, the year is divisible by 400).
module bcd_leap_year (
   input  logic [15:0] year_i,
   output logic        leap_o
);

   // Two BCD digits T,O form a multiple of 4 exactly when T is even and
   // O is 0/4/8, or T is odd and O is 2/6 (since 10*T mod 4 = 2*(T mod 2)).
   function automatic logic bcd2_div4(input logic [7:0] v);
      logic [3:0] t;
      logic [3:0] o;
      t = v[7:4];
      o = v[3:0];
      if (t[0])
         return (o == 4'd2) || (o == 4'd6);
      return (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
   endfunction

   always_comb begin
      if (year_i[7:0] == 8'h00)
         leap_o = bcd2_div4(year_i[15:8]);
      else
         leap_o = bcd2_div4(year_i[7:0]);
   end

endmodule

module bcd_calendar_sequencer #(
   parameter logic [15:0] RESET_YEAR  = 16'h2000,
   parameter logic [7:0]  RESET_MONTH = 8'h01,
   parameter logic [7:0]  RESET_DAY   = 8'h01
`ifdef CAL_DOW_EN
   ,
   parameter logic [2:0]  RESET_DOW   = 3'd6
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_year,
   input  logic [7:0]  load_month,
   input  logic [7:0]  load_day,
`ifdef CAL_DOW_EN
   input  logic [2:0]  load_dow,
   output logic [2:0]  dow,
`endif
   input  logic        adv,
   output logic        ready,
   output logic [15:0] year,
   output logic [7:0]  month,
   output logic [7:0]  day,
   output logic        leap,
   output logic        year_wrap,
   output logic        load_err
);

   typedef enum logic [1:0] {
      EVAL = 2'd0,
      IDLE = 2'd1,
      LCHK = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] year_q, year_d;
   logic [7:0]  month_q, month_d;
   logic [7:0]  day_q, day_d;
   logic        leap_q, leap_d;
   logic        wrap_q, wrap_d;
   logic        err_q, err_d;

   // Shadow copy of a load request while it is being checked.
   logic [15:0] sh_year_q, sh_year_d;
   logic [7:0]  sh_month_q, sh_month_d;
   logic [7:0]  sh_day_q, sh_day_d;

`ifdef CAL_DOW_EN
   logic [2:0]  dow_q, dow_d;
   logic [2:0]  sh_dow_q, sh_dow_d;
`endif

   logic [15:0] ly_year;
   logic        ly_leap;
   logic [7:0]  cur_len;
   logic [7:0]  sh_len;
   logic [16:0] year_inc;
   logic        load_ok;

   // BCD increment of a two-digit value; callers never exceed 31.
   function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return v + 8'd1;
   endfunction

   // BCD increment of a four-digit year; bit 16 is the carry out of 9999.
   function automatic logic [16:0] bcd4_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return {c, r};
   endfunction

   // Month length as a BCD day number. Unknown months report 31; such
   // months can only be seen while checking a load, which rejects them.
   function automatic logic [7:0] month_len(input logic [7:0] m, input logic lp);
      case (m)
         8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: return 8'h31;
         8'h04, 8'h06, 8'h09, 8'h11:                      return 8'h30;
         8'h02:                                           return lp ? 8'h29 : 8'h28;
         default:                                         return 8'h31;
      endcase
   endfunction

   function automatic logic digits_ok(input logic [31:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (v[4*i +: 4] > 4'd9)
            ok = 1'b0;
      end
      return ok;
   endfunction

   // The shared evaluator looks at the pending load while checking it,
   // and at the live year the rest of the time.
   assign ly_year = (state_q == LCHK) ? sh_year_q : year_q;

   bcd_leap_year u_leap_year (
      .year_i (ly_year),
      .leap_o (ly_leap)
   );

   assign cur_len  = month_len(month_q, leap_q);
   assign sh_len   = month_len(sh_month_q, ly_leap);
   assign year_inc = bcd4_inc(year_q);

   // With every digit known to be 0..9, plain binary compares of packed BCD
   // values order the same way as the decimal numbers they encode.
   assign load_ok = digits_ok({sh_year_q, sh_month_q, sh_day_q})
                 && (sh_month_q >= 8'h01) && (sh_month_q <= 8'h12)
                 && (sh_day_q != 8'h00) && (sh_day_q <= sh_len)
`ifdef CAL_DOW_EN
                 && (sh_dow_q <= 3'd6)
`endif
                 ;

   always_comb begin
      state_d    = state_q;
      year_d     = year_q;
      month_d    = month_q;
      day_d      = day_q;
      leap_d     = leap_q;
      wrap_d     = 1'b0;
      err_d      = 1'b0;
      sh_year_d  = sh_year_q;
      sh_month_d = sh_month_q;
      sh_day_d   = sh_day_q;
`ifdef CAL_DOW_EN
      dow_d      = dow_q;
      sh_dow_d   = sh_dow_q;
`endif

      case (state_q)
         EVAL: begin
            leap_d  = ly_leap;
            state_d = IDLE;
         end

         IDLE: begin
            if (load) begin
               // A simultaneous adv is intentionally dropped.
               sh_year_d  = load_year;
               sh_month_d = load_month;
               sh_day_d   = load_day;
`ifdef CAL_DOW_EN
               sh_dow_d   = load_dow;
`endif
               state_d    = LCHK;
            end else if (adv) begin
`ifdef CAL_DOW_EN
               dow_d = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
`endif
               if (day_q < cur_len) begin
                  day_d = bcd2_inc(day_q);
               end else begin
                  day_d = 8'h01;
                  if (month_q < 8'h12) begin
                     month_d = bcd2_inc(month_q);
                  end else begin
                     // New year: the leap flag is stale until EVAL refreshes it.
                     month_d = 8'h01;
                     year_d  = year_inc[15:0];
                     wrap_d  = year_inc[16];
                     state_d = EVAL;
                  end
               end
            end
         end

         LCHK: begin
            if (load_ok) begin
               year_d  = sh_year_q;
               month_d = sh_month_q;
               day_d   = sh_day_q;
               leap_d  = ly_leap;
`ifdef CAL_DOW_EN
               dow_d   = sh_dow_q;
`endif
            end else begin
               err_d = 1'b1;
            end
            state_d = IDLE;
         end

         default: begin
            state_d = EVAL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EVAL;
         year_q  <= RESET_YEAR;
         month_q <= RESET_MONTH;
         day_q   <= RESET_DAY;
         leap_q  <= 1'b0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef CAL_DOW_EN
         dow_q   <= RESET_DOW;
`endif
      end else begin
         state_q <= state_d;
         year_q  <= year_d;
         month_q <= month_d;
         day_q   <= day_d;
         leap_q  <= leap_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
`ifdef CAL_DOW_EN
         dow_q   <= dow_d;
`endif
      end
   end

   // Shadow registers carry data only; their content is irrelevant until a
   // load is captured, so they are not reset.
   always_ff @(posedge clk) begin
      sh_year_q  <= sh_year_d;
      sh_month_q <= sh_month_d;
      sh_day_q   <= sh_day_d;
`ifdef CAL_DOW_EN
      sh_dow_q   <= sh_dow_d;
`endif
   end

   assign ready     = (state_q == IDLE);
   assign year      = year_q;
   assign month     = month_q;
   assign day       = day_q;
   assign leap      = leap_q;
   assign year_wrap = wrap_q;
   assign load_err  = err_q;
`ifdef CAL_DOW_EN
   assign dow       = dow_q;
`endif

endmodule
